// File: rtl/framebuffer_ram.sv
// Dual-port framebuffer: host write port, registered scan-out read port, and a
// fill engine that writes one constant word to every location, one per cycle.
module framebuffer_ram #(
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 307200,
  parameter int ADDR_W    = 19,
  parameter     INIT_FILE = "",
  parameter int RDW_MODE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q, rd_word;
  logic              rd_valid_q;
  logic              wr_in_range, rd_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;

  // ---------------- fill FSM ----------------
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // combinational blocks use = and assign defaults first so no latch is inferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          fill_val_d = fill_value;
        end
      end
      ST_FILL: begin
        // Counter stops at the last word instead of wrapping past DEPTH.
        if (cnt_q == LAST_ADDR) state_d = ST_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_FILL);
  assign done = (state_q == ST_DONE);

  // ---------------- shared write port ----------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr[IDX_W-1:0];
    mem_wdata = wr_data;
    if (!reset) begin
      if (state_q == ST_FILL) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[IDX_W-1:0];
        mem_wdata = fill_val_q;
      end else if (wr_en && wr_in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: memory has no reset branch so it maps onto block RAM and keeps its
  // contents across reset; the write is gated off on reset edges instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------- read port ----------------
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (RDW_MODE != 0 && mem_we && mem_waddr == rd_addr[IDX_W-1:0]) rd_word = mem_wdata;
      else                                                             rd_word = mem_q[rd_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_framebuffer_ram.sv
// Bench for framebuffer_ram at DEPTH=16: directed table, fill/abort/refill
// sequences, then random traffic against a behavioural model.
module tb_framebuffer_ram;

  localparam int DW = 12;
  localparam int D  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0, we = 1'b0, re = 1'b0, fs = 1'b0;
  logic [AW-1:0] wa = '0, ra = '0;
  logic [DW-1:0] wd = '0, fv = '0;
  logic [DW-1:0] rd0, rd1;
  logic          v0, v1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  framebuffer_ram #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .INIT_FILE(""), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(re), .rd_addr(ra), .rd_data(rd0), .rd_valid(v0),
    .fill_start(fs), .fill_value(fv), .busy(busy0), .done(done0));

  framebuffer_ram #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .INIT_FILE(""), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(re), .rd_addr(ra), .rd_data(rd1), .rd_valid(v1),
    .fill_start(fs), .fill_value(fv), .busy(busy1), .done(done1));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: memory array plus "fill in progress at index i" bookkeeping.
  logic [DW-1:0] m_mem [D];
  bit            m_fill = 0, m_done = 0;
  int            m_idx = 0;
  logic [DW-1:0] m_val = '0;
  logic          e_valid = 0;
  logic [DW-1:0] e_d0 = '0, e_d1 = '0;

  task automatic model_update();
    bit            w;
    int            waddr;
    logic [DW-1:0] wdat;
    if (rst) begin
      e_valid = 0; e_d0 = '0; e_d1 = '0;
      m_fill = 0; m_done = 0; m_idx = 0;
    end else begin
      w = 0; waddr = 0; wdat = '0;
      if (m_fill) begin
        w = 1; waddr = m_idx; wdat = m_val;
      end else if (we && int'(wa) < D) begin
        w = 1; waddr = int'(wa); wdat = wd;
      end
      e_valid = re;
      if (re) begin
        if (int'(ra) >= D) begin
          e_d0 = '0; e_d1 = '0;
        end else begin
          e_d0 = m_mem[ra];
          e_d1 = (w && waddr == int'(ra)) ? wdat : m_mem[ra];
        end
      end
      if (m_fill) begin
        if (m_idx == D - 1) begin m_fill = 0; m_done = 1; end
        else m_idx++;
      end else if (m_done) begin
        m_done = 0;
      end else if (fs) begin
        m_fill = 1; m_idx = 0; m_val = fv;
      end
      if (w) m_mem[waddr] = wdat;
    end
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_update();
    #1;
    if (chk) begin
      check("rd_valid mode0", v0, e_valid);
      check("rd_valid mode1", v1, e_valid);
      check("rd_data mode0", rd0, e_d0);
      check("rd_data mode1", rd1, e_d1);
      check("busy mode0", busy0, m_fill);
      check("busy mode1", busy1, m_fill);
      check("done mode0", done0, m_done);
      check("done mode1", done1, m_done);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; we = 0; re = 0; fs = 0;
  endtask

  // Runs a fill started on the first cycle; optional second start at cycle 5.
  task automatic run_fill(input string nm, input logic [DW-1:0] val, input bit restart,
                          input logic [DW-1:0] val2, input bit host_wr);
    int nb = 0, nd = 0, done_at = -1, last_busy = -1;
    for (int k = 0; k < 30; k++) begin
      idle_inputs();
      if (k == 0) begin fs = 1; fv = val; end
      else if (k == 1) fv = ~val;
      if (restart && k == 5) begin fs = 1; fv = val2; end
      if (host_wr && k == 4) begin we = 1; wa = 5'd3; wd = 12'h0AA; end
      step(1);
      if (busy0) begin nb++; last_busy = k; end
      if (done0) begin nd++; done_at = k; end
    end
    idle_inputs();
    check({nm, " busy cycles"}, nb, D);
    check({nm, " done pulses"}, nd, 1);
    check({nm, " done after last busy"}, done_at, last_busy + 1);
    for (int i = 0; i < D; i++) begin
      re = 1; ra = AW'(i);
      step(1);
      check({nm, " readback"}, rd0, val);
    end
    idle_inputs();
  endtask

  typedef struct {
    logic          rst, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed0, ed1;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, int a, int d, logic rr, int b,
                              logic ev, int e0, int e1);
    vec_t v;
    v.rst = r; v.we = w; v.wa = AW'(a); v.wd = DW'(d); v.re = rr; v.ra = AW'(b);
    v.ev = ev; v.ed0 = DW'(e0); v.ed1 = DW'(e1);
    return v;
  endfunction

  vec_t tab [12];
  int   ndone;

  initial begin
    tab[0]  = mk(1, 0,  0, 'h000, 0,  0, 0, 'h000, 'h000);
    tab[1]  = mk(0, 1,  5, 'hABC, 0,  0, 0, 'h000, 'h000);
    tab[2]  = mk(0, 0,  0, 'h000, 1,  5, 1, 'hABC, 'hABC);
    tab[3]  = mk(0, 0,  0, 'h000, 0,  0, 0, 'hABC, 'hABC);
    tab[4]  = mk(0, 1,  7, 'h111, 0,  0, 0, 'hABC, 'hABC);
    tab[5]  = mk(0, 1,  7, 'h222, 1,  7, 1, 'h111, 'h222);
    tab[6]  = mk(0, 0,  0, 'h000, 1,  7, 1, 'h222, 'h222);
    tab[7]  = mk(0, 1,  0, 'h123, 0,  0, 0, 'h222, 'h222);
    tab[8]  = mk(0, 1, 16, 'h555, 1, 16, 1, 'h000, 'h000);
    tab[9]  = mk(0, 0,  0, 'h000, 1,  0, 1, 'h123, 'h123);
    tab[10] = mk(1, 1,  5, 'hFFF, 1,  5, 0, 'h000, 'h000);
    tab[11] = mk(0, 0,  0, 'h000, 1,  5, 1, 'hABC, 'hABC);

    for (int i = 0; i < 12; i++) begin
      rst = tab[i].rst; we = tab[i].we; wa = tab[i].wa; wd = tab[i].wd;
      re = tab[i].re; ra = tab[i].ra; fs = 0;
      step(0);
      check($sformatf("vec%0d rd_valid0", i), v0, tab[i].ev);
      check($sformatf("vec%0d rd_valid1", i), v1, tab[i].ev);
      check($sformatf("vec%0d rd_data0", i), rd0, tab[i].ed0);
      check($sformatf("vec%0d rd_data1", i), rd1, tab[i].ed1);
      check($sformatf("vec%0d busy", i), busy0 | busy1, 0);
      check($sformatf("vec%0d done", i), done0 | done1, 0);
    end
    idle_inputs();

    // Full fill with a host write dropped mid-fill.
    run_fill("fill", 12'hF0F, 0, 12'h000, 1);

    // Distinct background, then abort a fill after six written words.
    for (int i = 0; i < D; i++) begin
      we = 1; wa = AW'(i); wd = DW'(i * 'h11);
      step(1);
    end
    idle_inputs();
    fs = 1; fv = 12'h5A5;
    step(1);
    fs = 0;
    for (int k = 0; k < 6; k++) step(1);
    rst = 1;
    step(1);
    rst = 0;
    check("abort busy", busy0, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (done0 || done1) ndone++;
    end
    check("abort no done", ndone, 0);
    for (int i = 0; i < D; i++) begin
      re = 1; ra = AW'(i);
      step(1);
      check($sformatf("abort word%0d", i), rd0, (i < 6) ? 12'h5A5 : DW'(i * 'h11));
    end
    idle_inputs();

    // Second fill_start mid-fill must be ignored.
    run_fill("refill", 12'h333, 1, 12'h777, 0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      we  = $urandom_range(0, 1);
      wa  = AW'($urandom_range(0, 19));
      wd  = DW'($urandom);
      re  = $urandom_range(0, 1);
      ra  = AW'($urandom_range(0, 19));
      fs  = ($urandom_range(0, 39) == 0);
      fv  = DW'($urandom);
      step(1);
    end
    idle_inputs();
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_ram.md
FRAMEBUFFER_RAM -- requirements
Module: framebuffer_ram

Interface
REQ-001 Parameter DATA_W, default 12, pixel word width in bits.
REQ-002 Parameter DEPTH, default 307200, number of words (640x480).
REQ-003 Parameter ADDR_W, default 19, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter INIT_FILE, default "" (empty), binary init file loaded at elaboration; empty means no load.
REQ-005 Parameter RDW_MODE, default 0, same-address read-during-write result: 0 = old data, 1 = new data.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request, host port.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 rd_en  input  1  read request, scan-out port.
REQ-012 rd_addr  input  ADDR_W  read address.
REQ-013 rd_data  output  DATA_W  registered read data.
REQ-014 rd_valid  output  1  rd_data holds the result of a read.
REQ-015 fill_start  input  1  one-cycle pulse, starts a fill of the whole memory.
REQ-016 fill_value  input  DATA_W  fill word, sampled on the accepted fill_start cycle.
REQ-017 busy  output  1  fill in progress.
REQ-018 done  output  1  one-cycle pulse, fill completed.

Function
REQ-019 The read port SHALL have 1-cycle latency: rd_en at edge N gives rd_data and rd_valid=1 after edge N+1.
REQ-020 With rd_en=0, rd_valid SHALL be 0 after the next edge and rd_data SHALL hold its value.
REQ-021 A read with rd_addr >= DEPTH SHALL return 0 with rd_valid=1.
REQ-022 A write with wr_en=1, busy=0 and wr_addr < DEPTH SHALL update memory at that edge; wr_addr >= DEPTH SHALL be ignored.
REQ-023 Host writes while busy=1 SHALL be dropped; reads SHALL be served normally during a fill.
REQ-024 A read and a write (host or fill) to the same address on the same edge SHALL return old data if RDW_MODE=0 and the written data if RDW_MODE=1.
REQ-025 The fill FSM SHALL have states IDLE, FILL and DONE.
REQ-026 IDLE -> FILL on fill_start=1: latch fill_value, clear counter to 0, assert busy.
REQ-027 In FILL, one word per cycle SHALL be written at counter, then counter increments; after writing DEPTH-1 -> DONE.
REQ-028 DONE SHALL last one cycle with done=1 and busy=0, then -> IDLE.
REQ-029 A fill SHALL take exactly DEPTH cycles of busy=1, with done one cycle after the last write.
REQ-030 fill_start while in FILL or DONE SHALL be ignored, and fill_value changes after acceptance SHALL have no effect.
REQ-031 wr_en and fill_start on the same edge in IDLE: the host write SHALL complete and the fill SHALL start.
REQ-032 The counter SHALL be ADDR_W bits and SHALL never address >= DEPTH (no wrap).

Reset
REQ-033 reset=1 at an edge SHALL force rd_data=0, rd_valid=0, busy=0, done=0, FSM=IDLE and counter=0.
REQ-034 Reset SHALL NOT clear memory; contents (INIT_FILE or prior writes) SHALL survive.
REQ-035 Reset mid-fill SHALL abort the fill, leaving already-filled words written and the rest unchanged, with no done pulse.
REQ-036 reset SHALL take priority over fill_start, wr_en and rd_en on the same edge; no write occurs on a reset edge.

Verification
REQ-037 Write 0xABC at address 5, then read 5 next cycle -> rd_data=0xABC, rd_valid=1 exactly one cycle after rd_en.
REQ-038 RDW_MODE=0 (and RDW_MODE=1 separately): address 7 holds 0x111; write 0x222 and read 7 same edge -> 0x111 (resp. 0x222); a later read gives 0x222.
REQ-039 DEPTH=16: fill_start with fill_value=0xF0F -> busy=1 for 16 cycles, done pulse, all 16 addresses read 0xF0F; host write during busy leaves its target at 0xF0F.
REQ-040 DEPTH=16: reset after 6 fill cycles -> busy=0, no done, addresses 0-5 = fill value, 6-15 unchanged.
REQ-041 Write to address DEPTH and read address DEPTH -> no memory change, rd_data=0, rd_valid=1.
REQ-042 Second fill_start mid-fill with a different fill_value -> ignored; fill completes in DEPTH cycles with the original value.
